// File: rtl/stack_return_unit_pkg.sv
// Shared types and constants for the RET/RTI stack pop sequencer.
// Imported by the pop FSM and anything that observes its state.
package stack_return_unit_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_e;

   localparam logic MODE_RET = 1'b0;
   localparam logic MODE_RTI = 1'b1;

   localparam int STACK_WORD_W = 16;

endpackage

// File: rtl/stack_return_unit.sv
// Pops a return frame off the stack through the memory stage and
// restores PC (and CCR for RTI) with one atomic load pulse.
module stack_return_unit
   import stack_return_unit_pkg::*;
#(
   parameter int PC_W  = 16,
   parameter int CCR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ret_req,
   input  logic              rti_req,
   output logic              mem_pop,
   input  logic [15:0]       mem_rdata,
   output logic              stall,
   output logic              pc_load,
   output logic [PC_W-1:0]   pc_value,
   output logic              ccr_load,
   output logic [CCR_W-1:0]  ccr_value,
   output logic              busy
);

   localparam int PC_WORDS = PC_W / STACK_WORD_W;
   localparam int CNT_W    = $clog2(PC_WORDS + 2);

   localparam logic [CNT_W-1:0] CNT_RET = CNT_W'(PC_WORDS);
   localparam logic [CNT_W-1:0] CNT_RTI = CNT_W'(PC_WORDS + 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               mode_q, mode_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [CCR_W-1:0]   ccr_q, ccr_d;

   logic               first_rti_word;

   // Next-state, counter and frame reassembly.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      pc_d    = pc_q;
      ccr_d   = ccr_q;
      first_rti_word = (mode_q == MODE_RTI) && (cnt_q == CNT_RTI);
      unique case (state_q)
         IDLE: begin
            if (rti_req) begin
               mode_d  = MODE_RTI;
               cnt_d   = CNT_RTI;
               state_d = ISSUE;
            end else if (ret_req) begin
               mode_d  = MODE_RET;
               cnt_d   = CNT_RET;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            if (first_rti_word) begin
               ccr_d = mem_rdata[CCR_W-1:0];
            end else begin
               pc_d = (pc_q << STACK_WORD_W) | PC_W'(mem_rdata);
            end
            cnt_d   = cnt_q - CNT_ONE;
            state_d = (cnt_q == CNT_ONE) ? DONE : ISSUE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any partial frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mode_q  <= MODE_RET;
         pc_q    <= '0;
         ccr_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         pc_q    <= pc_d;
         ccr_q   <= ccr_d;
      end
   end

   assign mem_pop   = (state_q == ISSUE);
   assign pc_load   = (state_q == DONE);
   assign ccr_load  = (state_q == DONE) && (mode_q == MODE_RTI);
   assign busy      = (state_q != IDLE);
   assign stall     = ret_req | rti_req | busy;
   assign pc_value  = pc_q;
   assign ccr_value = ccr_q;

   a_no_req_busy: assert property (
      @(posedge clk) disable iff (!rst_n)
      busy |-> !(ret_req || rti_req));

   a_no_back_to_back_pop: assert property (
      @(posedge clk) disable iff (!rst_n)
      mem_pop |=> !mem_pop);

endmodule

// File: tb/tb_stack_return_unit.sv
// Randomised bench for stack_return_unit with 16- and 32-bit PCs.
// Frame model and cycle timing are derived from the frame layout.
module tb_stack_return_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] mem_rdata = '0;

   logic ret16 = 1'b0, rti16 = 1'b0;
   logic ret32 = 1'b0, rti32 = 1'b0;

   logic        pop16, stall16, pcl16, ccl16, busy16;
   logic [15:0] pc16;
   logic [2:0]  ccr16;
   logic        pop32, stall32, pcl32, ccl32, busy32;
   logic [31:0] pc32;
   logic [2:0]  ccr32;

   always #5 clk = ~clk;

   stack_return_unit #(.PC_W(16), .CCR_W(3)) u16 (
      .clk(clk), .rst_n(rst_n),
      .ret_req(ret16), .rti_req(rti16),
      .mem_pop(pop16), .mem_rdata(mem_rdata),
      .stall(stall16), .pc_load(pcl16),
      .pc_value(pc16), .ccr_load(ccl16),
      .ccr_value(ccr16), .busy(busy16)
   );

   stack_return_unit #(.PC_W(32), .CCR_W(3)) u32 (
      .clk(clk), .rst_n(rst_n),
      .ret_req(ret32), .rti_req(rti32),
      .mem_pop(pop32), .mem_rdata(mem_rdata),
      .stall(stall32), .pc_load(pcl32),
      .pc_value(pc32), .ccr_load(ccl32),
      .ccr_value(ccr32), .busy(busy32)
   );

   bit          cur = 1'b0;
   logic        o_pop, o_stall, o_pcl, o_ccl, o_busy;
   logic [31:0] o_pc;
   logic [2:0]  o_ccr;

   assign o_pop   = cur ? pop32   : pop16;
   assign o_stall = cur ? stall32 : stall16;
   assign o_pcl   = cur ? pcl32   : pcl16;
   assign o_ccl   = cur ? ccl32   : ccl16;
   assign o_busy  = cur ? busy32  : busy16;
   assign o_pc    = cur ? pc32    : {16'h0, pc16};
   assign o_ccr   = cur ? ccr32   : ccr16;

   // Stack memory: answers each pop with the next frame word.
   logic [15:0] frame [4];
   int          frame_base = 0;
   int          pops_total = 0;

   always @(posedge clk) begin
      if (o_pop) begin
         mem_rdata  <= frame[(pops_total - frame_base) & 3];
         pops_total <= pops_total + 1;
      end
   end

   int nvec = 0;
   int nerr = 0;
   logic [2:0] last_ccr [2];

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%h exp=%h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic drive(input bit sel, input bit rti,
                        input bit ret);
      if (sel) begin
         rti32 = rti;
         ret32 = ret;
      end else begin
         rti16 = rti;
         ret16 = ret;
      end
   endtask

   task automatic txn(input bit sel, input bit rti,
                      input bit ret, input logic [15:0] cw,
                      input logic [31:0] pc);
      int w, n, k, last;
      logic [31:0] epc;
      w = sel ? 2 : 1;
      n = w + (rti ? 1 : 0);
      last = 2 * n + 1;
      k = 0;
      if (rti) begin
         frame[0] = cw;
         k = 1;
      end
      for (int j = w - 1; j >= 0; j--) begin
         frame[k] = pc[16*j +: 16];
         k++;
      end
      epc = sel ? pc : {16'h0, pc[15:0]};
      if (rti) last_ccr[sel] = cw[2:0];
      @(negedge clk);
      cur = sel;
      frame_base = pops_total;
      drive(sel, rti, ret);
      #1;
      chk("req_stall", 32'(o_stall), 32'd1);
      chk("req_pop", 32'(o_pop), 32'd0);
      for (int i = 1; i <= last; i++) begin
         @(negedge clk);
         drive(sel, 1'b0, 1'b0);
         #1;
         chk("stall", 32'(o_stall), 32'd1);
         chk("busy", 32'(o_busy), 32'd1);
         chk("pop", 32'(o_pop),
             32'((i % 2 == 1) && (i < 2 * n)));
         chk("pc_load", 32'(o_pcl), 32'(i == last));
         chk("ccr_load", 32'(o_ccl),
             32'(rti && (i == last)));
         if (i == last) begin
            chk("pc_value", o_pc, epc);
            chk("ccr_value", 32'(o_ccr),
                32'(last_ccr[sel]));
         end
      end
      @(negedge clk);
      #1;
      chk("idle_stall", 32'(o_stall), 32'd0);
      chk("idle_busy", 32'(o_busy), 32'd0);
   endtask

   task automatic idle_check(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         #1;
         chk("gap_stall", 32'(o_stall), 32'd0);
         chk("gap_pcl", 32'(o_pcl), 32'd0);
      end
   endtask

   initial begin
      int sel, kind;
      last_ccr[0] = '0;
      last_ccr[1] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("rst16", {26'h0, pop16, stall16, pcl16,
                      ccl16, busy16, 1'b0}, 32'h0);
         chk("rst16_val", {13'h0, ccr16, pc16}, 32'h0);
         chk("rst32", {26'h0, pop32, stall32, pcl32,
                      ccl32, busy32, 1'b0}, 32'h0);
         chk("rst32_val", pc32 | 32'(ccr32), 32'h0);
         @(negedge clk);
      end

      txn(1'b0, 1'b0, 1'b1, 16'h0000, 32'h0000_01A4);
      txn(1'b0, 1'b1, 1'b0, 16'h0005, 32'h0000_3C20);
      txn(1'b0, 1'b1, 1'b1, 16'hFFFA, 32'h0000_7E11);
      txn(1'b1, 1'b0, 1'b1, 16'h0000, 32'hABCD_1234);
      txn(1'b1, 1'b1, 1'b1, 16'h0003, 32'h0F0F_8001);

      cur = 1'b0;
      frame[0] = 16'h0006;
      frame[1] = 16'h5555;
      @(negedge clk);
      frame_base = pops_total;
      rti16 = 1'b1;
      @(negedge clk);
      rti16 = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_stall_pre", 32'(o_stall), 32'd1);
      @(negedge clk);
      #1;
      chk("abort_stall", 32'(o_stall), 32'd0);
      chk("abort_busy", 32'(o_busy), 32'd0);
      chk("abort_pcl", 32'(o_pcl), 32'd0);
      chk("abort_ccl", 32'(o_ccl), 32'd0);
      chk("abort_pc", o_pc, 32'h0);
      chk("abort_ccr", 32'(o_ccr), 32'h0);
      last_ccr[0] = '0;
      last_ccr[1] = '0;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         chk("abort_nopulse", {30'h0, o_pcl, o_ccl}, 32'h0);
      end

      for (int t = 0; t < 40; t++) begin
         sel  = $urandom_range(0, 1);
         kind = $urandom_range(0, 2);
         txn(sel[0], kind != 0, kind != 1,
             16'($urandom), $urandom);
         idle_check($urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               nvec, nerr);
      $finish;
   end

endmodule

// File: doc/stack_return_unit.md
Name: stack_return_unit

Overview:
- Pop-side counterpart to the memory stage's interrupt/call push path (pushPc, pushCCR).
- On RET or RTI, sequences stack pops through the memory stage, reassembles the return PC, and restores the CCR on RTI.
- Holds the pipeline stalled until a single atomic PC/CCR load pulse is issued to fetch and the flag register.
- Sits beside the memory stage and drives that stage's pop request.

Parameters:
- PC_W, 16, return PC width; must be a multiple of 16.
- PC_WORDS, PC_W/16, number of 16-bit stack words per PC (derived, not user-set).
- CCR_W, 3, flag register width.

Ports:
- clk  in  1  pipeline clock, rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- ret_req  in  1  RET instruction present in the memory stage (single-cycle pulse).
- rti_req  in  1  RTI instruction present in the memory stage (single-cycle pulse).
- mem_pop  out  1  pop strobe to the memory stage; that stage reads at SP+1 and increments SP.
- mem_rdata  in  16  popped word, valid the cycle after mem_pop.
- stall  out  1  freeze IF/ID/EX and hold the memory-stage inputs.
- pc_load  out  1  one-cycle strobe: load pc_value into the PC.
- pc_value  out  PC_W  reassembled return address.
- ccr_load  out  1  one-cycle strobe: load ccr_value into the flag register (RTI only).
- ccr_value  out  CCR_W  restored flags.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, word counter=0, mode=0, mem_pop=0, pc_load=0, ccr_load=0, pc_value=0, ccr_value=0. Any partial sequence is discarded and no load pulse is issued. Reset dominates all requests.
- Stack layout is fixed by the push side: PC low word is pushed first, then higher words, then CCR (RTI frames only). The pop order is therefore CCR (RTI only), then PC high word down to PC low word.
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
  - IDLE: if rti_req, latch mode=RTI and count = PC_WORDS+1. Otherwise, if ret_req, latch mode=RET and count = PC_WORDS. Then go to ISSUE. If both requests are asserted, RTI wins.
  - ISSUE: mem_pop=1 for exactly this cycle. Go to CAPTURE.
  - CAPTURE: sample mem_rdata.
    - If mode=RTI and this is the first word, ccr_value <= mem_rdata[CCR_W-1:0]; upper bits are ignored.
    - Otherwise, shift the word into pc_value from the top: the first PC word popped fills bits [PC_W-1:PC_W-16].
    - Decrement count. If count reaches 0 go to DONE, else go to ISSUE.
  - DONE: pc_load=1. ccr_load=1 only if mode=RTI. Both strobes pulse in the same cycle (atomic restore). Next state is IDLE.
- Latency, counted from the request cycle T:
  - RET with PC_WORDS=1: ISSUE at T+1, CAPTURE at T+2, DONE at T+3. Back in IDLE at T+4.
  - General case: DONE at T + 2·words + 1.
- stall = ret_req | rti_req | (state != IDLE). It is combinational so the request cycle itself is frozen. It is high through DONE inclusive.
- Requests arriving while busy are ignored. The pipeline is stalled, so this is legal-by-construction. Assertion: no request while busy.
- pc_value and ccr_value hold their last values after DONE until the next capture.
- mem_pop is never asserted in two consecutive cycles.

Decomposition:
- Shared package holds:
  - state encoding enum: IDLE=2'd0, ISSUE=2'd1, CAPTURE=2'd2, DONE=2'd3;
  - mode constants MODE_RET and MODE_RTI;
  - STACK_WORD_W=16.
- No sub-module is needed. The word counter and PC shift register stay inline in a single FSM module.

Test Plan:
- Reset then idle → all outputs 0 and stall=0 for 5 cycles.
- RET pulse at T, stack returns 16'h01A4 → mem_pop high only at T+1; pc_load=1, pc_value=16'h01A4 at T+3; ccr_load=0; stall high T..T+3.
- RTI pulse, pops return 16'h0005 then 16'h3C20 → two mem_pop strobes (T+1, T+3); DONE at T+5 with ccr_value=3'b101, pc_value=16'h3C20, pc_load=ccr_load=1 in the same cycle.
- ret_req and rti_req asserted together → RTI sequence (2 pops, ccr_load=1).
- rst_n asserted low during CAPTURE of an RTI → next cycle IDLE, no pc_load/ccr_load ever pulses, stall=0.
- PC_W=32 RET, pops 16'hABCD then 16'h1234 → pc_value=32'hABCD1234 at T+5.
